// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: line filtering, 11-bit framing, E0/F0 prefix decode, FWFT event FIFO.
// Optional held-key table enabled by defining PS2_KEY_STATE_EN.
module ps2_key_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          KB_CLK,
    input  logic                          KB_DATA,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_break,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic [7:0]                    key_query_code,
    input  logic                          key_query_ext,
    output logic                          key_query_down
);

    localparam int FW = $clog2(FILTER_LEN) + 1;
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

    // Stage p0/p1: two-flop synchronisers on the raw keyboard lines
    logic kb_clk_p0, kb_clk_p1, kb_data_p0, kb_data_p1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            kb_clk_p0  <= 1'b1;
            kb_clk_p1  <= 1'b1;
            kb_data_p0 <= 1'b1;
            kb_data_p1 <= 1'b1;
        end else begin
            kb_clk_p0  <= KB_CLK;
            kb_clk_p1  <= kb_clk_p0;
            kb_data_p0 <= KB_DATA;
            kb_data_p1 <= kb_data_p0;
        end
    end

    // Stage p2: filtered levels and the one-cycle falling-edge strobe
    logic [FW-1:0] clk_cnt, data_cnt;
    logic          clk_flt_p2, data_flt_p2, fall_p2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            clk_flt_p2 <= 1'b1;
            clk_cnt    <= '0;
            fall_p2    <= 1'b0;
        end else begin
            fall_p2 <= 1'b0;
            if (kb_clk_p1 == clk_flt_p2) begin
                clk_cnt <= '0;
            end else if (clk_cnt == FW'(FILTER_LEN - 1)) begin
                clk_flt_p2 <= kb_clk_p1;
                clk_cnt    <= '0;
                fall_p2    <= ~kb_clk_p1;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            data_flt_p2 <= 1'b1;
            data_cnt    <= '0;
        end else if (kb_data_p1 == data_flt_p2) begin
            data_cnt <= '0;
        end else if (data_cnt == FW'(FILTER_LEN - 1)) begin
            data_flt_p2 <= kb_data_p1;
            data_cnt    <= '0;
        end else begin
            data_cnt <= data_cnt + 1'b1;
        end
    end

    // Stage p3: frame FSM and watchdog, registered byte/error pulses
    state_t        state, state_nxt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [WW-1:0] wd_cnt;
    logic          byte_ok, perr_nxt, ferr_nxt, timeout;

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        byte_ok   = 1'b0;
        perr_nxt  = 1'b0;
        ferr_nxt  = 1'b0;
        timeout   = 1'b0;
        if (state != S_IDLE && !fall_p2 && wd_cnt >= WW'(TIMEOUT_CYC - 1)) begin
            timeout   = 1'b1;
            ferr_nxt  = 1'b1;
            state_nxt = S_IDLE;
        end else if (fall_p2) begin
            case (state)
                S_IDLE:   if (!data_flt_p2) state_nxt = S_DATA;
                S_DATA:   if (bit_idx == 3'd7) state_nxt = S_PARITY;
                S_PARITY: state_nxt = S_STOP;
                S_STOP: begin
                    state_nxt = S_IDLE;
                    if (!data_flt_p2)                         ferr_nxt = 1'b1;
                    else if (!odd_parity_ok({par_bit, shreg})) perr_nxt = 1'b1;
                    else                                      byte_ok  = 1'b1;
                end
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (fall_p2) begin
            case (state)
                S_IDLE:   bit_idx <= 3'd0;
                S_DATA: begin
                    shreg   <= {data_flt_p2, shreg[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
                S_PARITY: par_bit <= data_flt_p2;
                default:  ;
            endcase
        end
    end

    // Watchdog counts cycles since the last fall; the fall cycle itself is cycle 0
    always_ff @(posedge CLK) begin
        if (RST)                    wd_cnt <= '0;
        else if (fall_p2)           wd_cnt <= WW'(1);
        else if (timeout)           wd_cnt <= '0;
        else if (state != S_IDLE)   wd_cnt <= wd_cnt + 1'b1;
    end

    logic       byte_done_p3;
    logic [7:0] byte_p3;

    always_ff @(posedge CLK) begin
        if (RST) begin
            byte_done_p3 <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            byte_done_p3 <= byte_ok;
            parity_err   <= perr_nxt;
            frame_err    <= ferr_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (byte_ok) byte_p3 <= shreg;
    end

    // Stage p4: prefix decode and push into the event FIFO
    logic       ext_flag, brk_flag, push;
    logic [9:0] push_word;

    assign push      = byte_done_p3 && (byte_p3 != 8'hE0) && (byte_p3 != 8'hF0);
    assign push_word = {ext_flag, brk_flag, byte_p3};

    always_ff @(posedge CLK) begin
        if (RST || parity_err || frame_err) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else if (byte_done_p3) begin
            if (byte_p3 == 8'hE0) begin
                ext_flag <= 1'b1;
            end else if (byte_p3 == 8'hF0) begin
                brk_flag <= 1'b1;
            end else begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end
        end
    end

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          pop, full, wr_en;
    logic [9:0]    head;

    assign pop   = (count != '0) && evt_ready;
    assign full  = (count == (AW + 1)'(FIFO_DEPTH));
    assign wr_en = push && (!full || pop);

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            overflow <= push && full && !pop;
        end
    end

    assign head       = mem[rd_ptr];
    assign evt_valid  = (count != '0);
    assign evt_code   = evt_valid ? head[7:0] : 8'h00;
    assign evt_ext    = evt_valid & head[9];
    assign evt_break  = evt_valid & head[8];
    assign fifo_count = count;

`ifdef PS2_KEY_STATE_EN
    // Table follows every decoded event, including ones the FIFO had to drop
    logic [511:0] key_tbl;
    logic [8:0]   upd_idx, q_idx;

    assign upd_idx = {ext_flag, byte_p3};
    assign q_idx   = {key_query_ext, key_query_code};

    always_ff @(posedge CLK) begin
        if (RST) begin
            key_tbl        <= '0;
            key_query_down <= 1'b0;
        end else begin
            if (push) key_tbl[upd_idx] <= ~brk_flag;
            if (push && upd_idx == q_idx) key_query_down <= ~brk_flag;
            else                          key_query_down <= key_tbl[q_idx];
        end
    end
`else
    logic unused_query;
    assign unused_query   = ^{key_query_code, key_query_ext};
    assign key_query_down = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed frames plus random traffic against a byte-level event model.
module tb_ps2_key_decoder;
    localparam int FL    = 4;
    localparam int DEPTH = 4;
    localparam int TO    = 300;
    localparam int HALF  = 16;
    localparam int GAP   = 40;

    logic       CLK = 1'b0, RST = 1'b1, KB_CLK = 1'b1, KB_DATA = 1'b1, evt_ready = 1'b0;
    logic       evt_valid, evt_ext, evt_break, parity_err, frame_err, overflow, key_query_down;
    logic [7:0] evt_code;
    logic [7:0] key_query_code = 8'h00;
    logic       key_query_ext = 1'b0;
    logic [$clog2(DEPTH):0] fifo_count;

    ps2_key_decoder #(.FILTER_LEN(FL), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .CLK(CLK), .RST(RST), .KB_CLK(KB_CLK), .KB_DATA(KB_DATA),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_ext(evt_ext), .evt_break(evt_break), .fifo_count(fifo_count),
        .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow),
        .key_query_code(key_query_code), .key_query_ext(key_query_ext),
        .key_query_down(key_query_down)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int   perr_n = 0, ferr_n = 0, ovf_n = 0, ferr_cyc = 0, rise_cyc = 0;
    logic prev_v = 1'b0;
    always @(negedge CLK) begin
        if (parity_err) perr_n++;
        if (frame_err) begin ferr_n++; ferr_cyc = cyc; end
        if (overflow) ovf_n++;
        if (evt_valid && !prev_v) rise_cyc = cyc;
        prev_v = evt_valid;
    end

    // Reference model: decoded events at byte granularity
    logic [9:0] exp_q[$];
    logic       m_ext = 1'b0, m_brk = 1'b0;
    int         exp_ovf = 0;
    logic       key_m [512];
    int         key_touched[$];

    task automatic model_reset();
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        for (int i = 0; i < 512; i++) key_m[i] = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            m_ext = 1'b0; m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, b});
            else exp_ovf++;
            key_m[{m_ext, b}] = ~m_brk;
            key_touched.push_back(int'({m_ext, b}));
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endtask

    int total = 0, bad = 0;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input bit glitch, output int stop_fall);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        stop_fall = 0;
        for (int i = 0; i < 11; i++) begin
            KB_DATA = bits[i];
            tick(HALF);
            KB_CLK = 1'b0;
            if (i == 10) stop_fall = cyc;
            tick(HALF);
            KB_CLK = 1'b1;
            if (glitch && i == 4) begin
                tick(HALF / 2);
                KB_CLK = 1'b0;
                tick(1);
                KB_CLK = 1'b1;
                tick(HALF / 2);
            end
        end
        KB_DATA = 1'b1;
        tick(GAP);
        model_byte(b, !bad_par && !bad_stop);
    endtask

    task automatic send_partial(input int nbits, output int last_fall);
        last_fall = 0;
        for (int i = 0; i <= nbits; i++) begin
            KB_DATA = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            tick(HALF);
            KB_CLK = 1'b0;
            last_fall = cyc;
            tick(HALF);
            KB_CLK = 1'b1;
        end
        KB_DATA = 1'b1;
    endtask

    task automatic check_fifo(input string tag);
        check({tag, "_count"}, fifo_count, exp_q.size());
        if (exp_q.size() == 0) begin
            check({tag, "_valid"}, evt_valid, 0);
            check({tag, "_code"}, evt_code, 0);
            check({tag, "_flags"}, {evt_ext, evt_break}, 0);
        end else begin
            check({tag, "_valid"}, evt_valid, 1);
            check({tag, "_code"}, evt_code, exp_q[0][7:0]);
            check({tag, "_flags"}, {evt_ext, evt_break}, exp_q[0][9:8]);
        end
    endtask

    task automatic pop_one(input string tag);
        check_fifo(tag);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic query(input string tag, input logic ext, input logic [7:0] code, input logic exp);
        key_query_ext  = ext;
        key_query_code = code;
        tick(1);
        check(tag, key_query_down, exp);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int sf, lf, p0, f0, o0, e0, nbadpar, n;
        logic [7:0] b;
        logic [7:0] ovf_exp [4];
        ovf_exp[0] = 8'h15; ovf_exp[1] = 8'h1D; ovf_exp[2] = 8'h24; ovf_exp[3] = 8'h2D;
        model_reset();

        tick(4);
        check("rst_valid", evt_valid, 0);
        check("rst_code", evt_code, 0);
        check("rst_flags", {evt_ext, evt_break}, 0);
        check("rst_count", fifo_count, 0);
        check("rst_errs", {parity_err, frame_err, overflow}, 0);
        check("rst_keydown", key_query_down, 0);
        RST = 1'b0;
        tick(5);

        send_byte(8'h1C, 0, 0, 0, sf);
        check("t1_latency", rise_cyc, sf + FL + 4);
        check("t1_code", evt_code, 8'h1C);
        check("t1_flags", {evt_ext, evt_break}, 0);
        check("t1_count", fifo_count, 1);
        pop_one("t1_pop");
        check_fifo("t1_empty");

        send_byte(8'hE0, 0, 0, 0, sf);
        send_byte(8'hF0, 0, 0, 0, sf);
        send_byte(8'h75, 0, 0, 0, sf);
        check("t2_count", fifo_count, 1);
        check("t2_code", evt_code, 8'h75);
        check("t2_flags", {evt_ext, evt_break}, 2'b11);
        pop_one("t2_pop");
        check("t2_valid_after", evt_valid, 0);
        check("t2_code_after", evt_code, 0);

        p0 = perr_n;
        send_byte(8'hE0, 0, 0, 0, sf);
        send_byte(8'h29, 1, 0, 0, sf);
        send_byte(8'h29, 0, 0, 0, sf);
        check("t3_perr", perr_n - p0, 1);
        check("t3_code", evt_code, 8'h29);
        check("t3_ext", evt_ext, 0);
        pop_one("t3_pop");

        o0 = ovf_n;
        e0 = exp_ovf;
        send_byte(8'h15, 0, 0, 0, sf);
        send_byte(8'h1D, 0, 0, 0, sf);
        send_byte(8'h24, 0, 0, 0, sf);
        send_byte(8'h2D, 0, 0, 0, sf);
        send_byte(8'h2C, 0, 0, 0, sf);
        check("t4_count", fifo_count, 4);
        check("t4_ovf", ovf_n - o0, 1);
        check("t4_model_ovf", exp_ovf - e0, 1);
        for (int i = 0; i < 4; i++) begin
            check("t4_order", evt_code, ovf_exp[i]);
            pop_one("t4_pop");
        end
        check("t4_empty", evt_valid, 0);

        f0 = ferr_n;
        send_byte(8'hE0, 0, 0, 0, sf);
        send_partial(4, lf);
        n = 0;
        while (ferr_n == f0 && n < TO + 200) begin
            tick(1);
            n++;
        end
        check("t5_ferr_seen", ferr_n - f0, 1);
        check("t5_ferr_time", ferr_cyc, lf + FL + 2 + TO);
        model_byte(8'h00, 0);
        send_byte(8'h1B, 0, 0, 0, sf);
        check("t5_code", evt_code, 8'h1B);
        check("t5_ext", evt_ext, 0);
        pop_one("t5_pop");

        p0 = perr_n;
        f0 = ferr_n;
        send_byte(8'h33, 0, 0, 1, sf);
        check("t6_errs", (perr_n - p0) + (ferr_n - f0), 0);
        check("t6_code", evt_code, 8'h33);
        pop_one("t6_pop");

        f0 = ferr_n;
        send_byte(8'hE0, 0, 0, 0, sf);
        send_byte(8'h44, 0, 1, 0, sf);
        check("t7_ferr", ferr_n - f0, 1);
        check("t7_nopush", fifo_count, 0);
        send_byte(8'h44, 0, 0, 0, sf);
        check("t7_code", evt_code, 8'h44);
        check("t7_ext", evt_ext, 0);
        pop_one("t7_pop");

        p0 = perr_n;
        f0 = ferr_n;
        send_byte(8'hE0, 0, 0, 0, sf);
        send_partial(3, lf);
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        model_reset();
        tick(TO + 50);
        check("t8_noerr", (perr_n - p0) + (ferr_n - f0), 0);
        check_fifo("t8_empty");
        send_byte(8'h12, 0, 0, 0, sf);
        check("t8_code", evt_code, 8'h12);
        check("t8_ext", evt_ext, 0);
        pop_one("t8_pop");

`ifdef PS2_KEY_STATE_EN
        send_byte(8'hE0, 0, 0, 0, sf);
        send_byte(8'h75, 0, 0, 0, sf);
        query("t9_make_ext", 1'b1, 8'h75, 1'b1);
        query("t9_plain_75", 1'b0, 8'h75, 1'b0);
        send_byte(8'hE0, 0, 0, 0, sf);
        send_byte(8'hF0, 0, 0, 0, sf);
        send_byte(8'h75, 0, 0, 0, sf);
        query("t9_break_ext", 1'b1, 8'h75, 1'b0);
        send_byte(8'h1C, 0, 0, 0, sf);
        query("t9_make_1c", 1'b0, 8'h1C, 1'b1);
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        model_reset();
        query("t9_rst_1c", 1'b0, 8'h1C, 1'b0);
        query("t9_rst_12", 1'b0, 8'h12, 1'b0);
`else
        send_byte(8'h1C, 0, 0, 0, sf);
        query("t9_tied_1c", 1'b0, 8'h1C, 1'b0);
        query("t9_tied_ext", 1'b1, 8'h75, 1'b0);
`endif
        while (exp_q.size() > 0) pop_one("t9_drain");
        check_fifo("t9_empty");

        key_touched.delete();
        o0 = ovf_n;
        e0 = exp_ovf;
        p0 = perr_n;
        nbadpar = 0;
        for (int i = 0; i < 40; i++) begin
            int r;
            bit bp;
            r = $urandom_range(0, 9);
            if (r == 0) b = 8'hE0;
            else if (r == 1) b = 8'hF0;
            else begin
                do b = 8'($urandom_range(0, 255)); while (b == 8'hE0 || b == 8'hF0);
            end
            bp = ($urandom_range(0, 9) == 0);
            if (bp) nbadpar++;
            send_byte(b, bp, 0, 0, sf);
            check_fifo("rnd_state");
            if (exp_q.size() > 0 && $urandom_range(0, 2) == 0) pop_one("rnd_pop");
        end
        check("rnd_ovf", ovf_n - o0, exp_ovf - e0);
        check("rnd_perr", perr_n - p0, nbadpar);
`ifdef PS2_KEY_STATE_EN
        for (int i = 0; i < 8 && i < key_touched.size(); i++) begin
            logic [8:0] idx;
            idx = 9'(key_touched[i]);
            query("rnd_key", idx[8], idx[7:0], key_m[idx]);
        end
`endif
        while (exp_q.size() > 0) pop_one("rnd_drain");
        check_fifo("rnd_empty");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
